// File: rtl/noc_pkg.sv
// Shared NoC constants: flit-id codes, one-hot arbiter port codes and
// the requester state encoding.
package noc_pkg;

    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;

    localparam logic [5:0] PORT_L = 6'b000010;
    localparam logic [5:0] PORT_N = 6'b000100;
    localparam logic [5:0] PORT_E = 6'b001000;
    localparam logic [5:0] PORT_W = 6'b010000;
    localparam logic [5:0] PORT_S = 6'b100000;

    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SEND    = 2'd2,
        HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/flit_requester.sv
// Input-port requester: arbitrates for the crossbar on a header, forwards
// the packet flit by flit while granted, and flags length mismatches.
module flit_requester
    import noc_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [5:0] PORT_CODE = 6'b000010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    input  logic [5:0]        grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              err_len
);

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [2:0]         flit_id_q, flit_id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               err_q, err_d;
    logic               ready_c;
    logic               granted;

    // Multi-hot or foreign grant codes never count as ours.
    assign granted = (grant == PORT_CODE);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        flit_id_d   = flit_id_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        ready_c     = 1'b0;
        case (state_q)
            IDLE: begin
                flit_id_d = '0;
                if (in_valid) begin
                    if (in_flit_id == HEADER) begin
                        // Header stays in the FIFO; it is popped as the first flit in SEND.
                        len_d     = in_data[LEN_W-1:0];
                        err_d     = (in_data[LEN_W-1:0] == '0);
                        flit_id_d = HEADER;
                        state_d   = REQUEST;
                    end else begin
                        ready_c = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            REQUEST: begin
                if (granted) state_d = SEND;
            end
            SEND: begin
                if (!granted) begin
                    state_d = HOLD;
                end else begin
                    ready_c = 1'b1;
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        flit_id_d   = in_flit_id;
                        cnt_d       = (in_flit_id == HEADER) ? LEN_W'(1) : cnt_q + LEN_W'(1);
                        if (in_flit_id == TAIL) begin
                            err_d   = ((cnt_q + LEN_W'(1)) != len_q);
                            state_d = IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (granted) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            flit_id_q   <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            flit_id_q   <= flit_id_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    // Gated so a pending non-header flit cannot be popped while reset is held.
    assign in_ready  = rst & ready_c;
    assign req       = req_q;
    assign flit_id   = flit_id_q;
    assign length    = len_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_len   = err_q;

endmodule

// File: doc/flit_requester.md
FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning flit payload width.
REQ-002 The block SHALL have parameter PORT_CODE, default 6'b000010, meaning this port's one-hot grant code (L=000010, N=000100, E=001000, W=010000, S=100000).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the upstream flit FIFO handshake.
REQ-006 The block SHALL have port in_flit_id, input, 3 bits: 001=header, 010=body, 100=tail.
REQ-007 The block SHALL have port in_data, input, DATA_W bits; in a header flit, in_data[11:0] is the packet length in flits.
REQ-008 The block SHALL have port grant, input, 6 bits: the one-hot arbiter state.
REQ-009 The block SHALL have port req, output, 1 bit: the request to the arbiter.
REQ-010 The block SHALL have ports flit_id (output, 3 bits) and length (output, 12 bits): the arbiter timer inputs.
REQ-011 The block SHALL have ports out_valid (output, 1 bit) and out_data (output, DATA_W bits): the crossbar-side flit.
REQ-012 The block SHALL have port err_len, output, 1 bit: a one-cycle error pulse.

Function
REQ-013 The block SHALL implement the states IDLE, REQUEST, SEND and HOLD.
REQ-014 In IDLE with in_valid=1 and in_flit_id=001, the block SHALL latch length<=in_data[11:0], set req=1 and enter REQUEST without popping the header.
REQ-015 In IDLE with in_valid=1 and a non-header flit id, the block SHALL pop and drop the flit (in_ready=1) and pulse err_len.
REQ-016 In REQUEST, the block SHALL drive req=1 and flit_id=001 and hold in_ready=0.
REQ-017 The block SHALL treat "granted" as grant==PORT_CODE exactly; any other value, including multi-hot, SHALL count as not granted.
REQ-018 In REQUEST, the block SHALL enter SEND on the first cycle it is granted; until then it SHALL wait indefinitely.
REQ-019 In SEND while granted, the block SHALL set in_ready=1; each accepted flit SHALL appear on out_data with out_valid=1 and flit_id=in_flit_id exactly one cycle later (registered).
REQ-020 In SEND while not granted (arbiter timeout or preemption), the block SHALL enter HOLD.
REQ-021 In HOLD, the block SHALL hold in_ready=0 and req=1 and return to SEND when granted, with no flit lost or duplicated.
REQ-022 The block SHALL count accepted flits in a 12-bit counter starting at 1 on the header; the counter SHALL wrap modulo 4096.
REQ-023 On acceptance of a tail flit, the block SHALL pulse err_len if the count differs from the latched length.
REQ-024 A header flit with length field 0 SHALL pulse err_len and SHALL still be forwarded until its tail.
REQ-025 After tail acceptance the block SHALL return to IDLE with req=0 on the next cycle, and req SHALL stay low for at least one full cycle between packets.
REQ-026 A new header present in the same cycle as tail acceptance SHALL NOT be popped; it SHALL be processed from IDLE afterwards.
REQ-027 out_valid SHALL be 0 in every cycle in which no flit was accepted in the previous cycle.

Reset
REQ-028 Asserting rst low SHALL, asynchronously, force state=IDLE and clear req, flit_id, length, out_valid, out_data, err_len, in_ready and the flit counter to 0.
REQ-029 A reset asserted mid-packet SHALL abandon the packet; after reset the block SHALL drop body/tail flits and pulse err_len per REQ-015.

Structure
REQ-030 The package noc_pkg SHALL hold the flit-id constants (HEADER, BODY, TAIL), the port one-hot codes, and the state encoding.
REQ-031 The block SHALL be a single module with no sub-module; the counter and the state machine SHALL be inline.

Verification
REQ-032 The bench SHALL cover: header length=3, body, tail with grant held -> req high 3 cycles after grant, three out_valid pulses, req low after tail, no err_len.
REQ-033 The bench SHALL cover: grant held at 000100 while PORT_CODE=000010 -> block stays in REQUEST, in_ready=0, req=1 indefinitely.
REQ-034 The bench SHALL cover: grant dropped for 4 cycles after the 2nd flit of a 5-flit packet -> in_ready=0 during the gap, all 5 flits delivered in order exactly once.
REQ-035 The bench SHALL cover: header length=4 followed by a tail after 2 flits -> err_len pulse on tail acceptance, return to IDLE.
REQ-036 The bench SHALL cover: rst low mid-packet -> all outputs 0 immediately, leftover body/tail flits dropped with err_len pulses.
REQ-037 The bench SHALL cover: back-to-back packets with a header behind the tail -> at least one cycle of req=0 between the packets.
